// File: rtl/uart_rx.sv
// uart_rx: oversampling UART receiver with 2-of-3 majority sampling, optional parity and error flags.
module uart_rx #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic [5:0]            PRESCALE,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  Data_Valid,
  output logic                  Par_Err,
  output logic                  Stp_Err
);
  localparam int BW = $clog2(DATA_WIDTH);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  state_t                state;
  logic                  rx_m, rx_s;
  logic [5:0]            p, edge_cnt, half, p_in;
  logic [BW-1:0]         bit_cnt;
  logic                  pen, ptyp, par_fail, stp_fail, maj, at_hi, at_end, glitch;
  logic [1:0]            smp;
  logic [DATA_WIDTH-1:0] sreg;
  always_comb begin
    p_in   = (PRESCALE == 6'd16 || PRESCALE == 6'd32) ? PRESCALE : 6'd8;
    half   = p >> 1;
    at_hi  = edge_cnt == half + 6'd1;
    at_end = edge_cnt == p - 6'd1;
    maj    = (smp[0] & smp[1]) | (rx_s & (smp[0] | smp[1]));
    glitch = state == START && at_hi && maj;
  end
  always_ff @(posedge CLK or negedge RST)
    if (!RST) begin
      state      <= IDLE;
      rx_m       <= 1'b1;
      rx_s       <= 1'b1;
      p          <= 6'd8;
      edge_cnt   <= '0;
      bit_cnt    <= '0;
      pen        <= 1'b0;
      ptyp       <= 1'b0;
      smp        <= '0;
      sreg       <= '0;
      par_fail   <= 1'b0;
      stp_fail   <= 1'b0;
      P_DATA     <= '0;
      Data_Valid <= 1'b0;
      Par_Err    <= 1'b0;
      Stp_Err    <= 1'b0;
    end else begin
      rx_m       <= RX_IN;
      rx_s       <= rx_m;
      Data_Valid <= 1'b0;
      Par_Err    <= 1'b0;
      Stp_Err    <= 1'b0;
      if (edge_cnt == half - 6'd1) smp[0] <= rx_s;
      if (edge_cnt == half) smp[1] <= rx_s;
      // the detecting IDLE cycle is edge 0 of the start bit
      edge_cnt <= (state == IDLE) ? {5'd0, ~rx_s} : (at_end || glitch) ? 6'd0 : edge_cnt + 6'd1;
      case (state)
        IDLE: if (!rx_s) begin
          state    <= START;
          p        <= p_in;
          pen      <= PAR_EN;
          ptyp     <= PAR_TYP;
          par_fail <= 1'b0;
          stp_fail <= 1'b0;
          bit_cnt  <= '0;
        end
        START: state <= glitch ? IDLE : at_end ? DATA : START;
        DATA: begin
          if (at_hi) sreg <= {maj, sreg[DATA_WIDTH-1:1]};
          if (at_end) begin
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == BW'(DATA_WIDTH - 1)) state <= pen ? PARITY : STOP;
          end
        end
        PARITY: begin
          if (at_hi) par_fail <= maj ^ (^sreg) ^ ptyp;
          if (at_end) state <= STOP;
        end
        STOP: begin
          if (at_hi) stp_fail <= ~maj;
          if (at_end) begin
            state      <= IDLE;
            P_DATA     <= sreg;
            Data_Valid <= ~par_fail & ~stp_fail;
            Par_Err    <= par_fail;
            Stp_Err    <= stp_fail;
          end
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed and randomized frames checked against a frame-level timing/flag model.
module tb_uart_rx;
  logic       CLK = 1'b0, RST = 1'b0, RX_IN = 1'b1, PAR_EN = 1'b0, PAR_TYP = 1'b0;
  logic [5:0] PRESCALE = 6'd8;
  logic [7:0] P_DATA;
  logic       Data_Valid, Par_Err, Stp_Err;
  int         n_chk = 0, n_err = 0;
  int unsigned cyc = 0;
  typedef struct {
    int unsigned cyc;
    logic dv, pe, se;
    logic [7:0] d;
  } ev_t;
  ev_t exp_q[$], act_q[$];
  logic [5:0] ps_tab [6] = '{6'd8, 6'd16, 6'd32, 6'd12, 6'd0, 6'd63};

  uart_rx dut (
    .CLK(CLK), .RST(RST), .RX_IN(RX_IN), .PRESCALE(PRESCALE), .PAR_EN(PAR_EN),
    .PAR_TYP(PAR_TYP), .P_DATA(P_DATA), .Data_Valid(Data_Valid), .Par_Err(Par_Err),
    .Stp_Err(Stp_Err)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;
  always @(negedge CLK)
    if (RST && (Data_Valid || Par_Err || Stp_Err)) begin
      ev_t a;
      a.cyc = cyc; a.dv = Data_Valid; a.pe = Par_Err; a.se = Stp_Err; a.d = P_DATA;
      act_q.push_back(a);
    end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    assert (got === want) else begin
      n_err++;
      $error("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  task automatic drive_bit(input logic v, input int n);
    RX_IN = v;
    repeat (n) @(posedge CLK);
    #1;
  endtask

  // A frame started on the line at cycle k pulses at k + 2 (synchronizer) + bits * bit_time.
  task automatic send_frame(input logic [7:0] b, input logic [5:0] ps, input logic pen, input logic typ,
                            input logic bad_par, input logic stop, input logic scr);
    int p;
    int unsigned k;
    ev_t e;
    p = (ps == 6'd16 || ps == 6'd32) ? int'(ps) : 8;
    k = cyc;
    PRESCALE = ps; PAR_EN = pen; PAR_TYP = typ;
    drive_bit(1'b0, p);
    if (scr) begin
      PRESCALE = 6'($urandom); PAR_EN = 1'($urandom); PAR_TYP = 1'($urandom);
    end
    for (int i = 0; i < 8; i++) drive_bit(b[i], p);
    if (pen) drive_bit((^b) ^ typ ^ bad_par, p);
    drive_bit(stop, p);
    e.cyc = k + 2 + unsigned'((pen ? 11 : 10) * p);
    e.pe  = pen & bad_par;
    e.se  = ~stop;
    e.dv  = ~e.pe & ~e.se;
    e.d   = b;
    exp_q.push_back(e);
  endtask

  task automatic check_events(input string tag);
    RX_IN = 1'b1;
    repeat (6) @(posedge CLK);
    #1;
    chk({tag, "_count"}, act_q.size(), exp_q.size());
    while (exp_q.size() > 0 && act_q.size() > 0) begin
      ev_t e, a;
      e = exp_q.pop_front();
      a = act_q.pop_front();
      chk({tag, "_cycle"}, a.cyc, e.cyc);
      chk({tag, "_dv_pe_se_data"}, {a.dv, a.pe, a.se, a.d}, {e.dv, e.pe, e.se, e.d});
    end
    exp_q.delete();
    act_q.delete();
  endtask

  initial begin
    repeat (3) @(posedge CLK);
    #1;
    chk("reset_outputs", {P_DATA, Data_Valid, Par_Err, Stp_Err}, 32'd0);
    RST = 1'b1;
    drive_bit(1'b1, 5);
    send_frame(8'hA5, 6'd8, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    check_events("even_parity_ok");
    send_frame(8'hA5, 6'd16, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    check_events("odd_parity_err");
    // stop bit low, then the still-low line becomes the start of an all-zero frame
    send_frame(8'h3C, 6'd8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    send_frame(8'h00, 6'd8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check_events("break_restart");
    PRESCALE = 6'd16;
    drive_bit(1'b0, 3);
    drive_bit(1'b1, 8);
    send_frame(8'h55, 6'd16, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check_events("glitch_then_frame");
    PRESCALE = 6'd16; PAR_EN = 1'b0;
    drive_bit(1'b0, 16);
    for (int i = 0; i < 4; i++) drive_bit(i[0], 16);
    drive_bit(1'b1, 8);
    RST = 1'b0;
    #1;
    chk("reset_mid_frame", {P_DATA, Data_Valid, Par_Err, Stp_Err}, 32'd0);
    drive_bit(1'b1, 3);
    RST = 1'b1;
    drive_bit(1'b1, 40);
    check_events("after_reset_quiet");
    send_frame(8'h96, 6'd16, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check_events("after_reset_frame");
    send_frame(8'h01, 6'd32, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    send_frame(8'hFF, 6'd32, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    send_frame(8'h80, 6'd32, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check_events("back_to_back");
    for (int n = 0; n < 16; n++) begin
      send_frame(8'($urandom), ps_tab[$urandom_range(0, 5)], 1'($urandom), 1'($urandom),
                 1'($urandom), $urandom_range(0, 3) != 0, 1'($urandom));
      if ($urandom_range(0, 1) == 1) drive_bit(1'b1, $urandom_range(1, 20));
    end
    check_events("random");
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
